axi_read_arbiter: RTL and testbench
===================================

# axi_read_arbiter

Round-robin arbiter sharing one AXI4 read port (AR + R channels) among NUM_MASTERS upstream requesters. It sits between the testbench read initiators and the single DUT slave read port. It registers the winning AR payload and holds it stable until accepted, so it satisfies the payload-hold rule on the downstream AR channel. It tags the downstream ARID with the requester index, routes R beats back by that tag, and caps outstanding bursts.

## Interface
- NUM_MASTERS, 4, number of upstream requesters (2..8); IDX_W = $clog2(NUM_MASTERS)
- AXI_ADDR_WIDTH, 32, address width
- AXI_DATA_WIDTH, 32, data width
- AXI_ID_WIDTH, 8, downstream ID width; upstream ID width UID_W = AXI_ID_WIDTH - IDX_W
- MAX_OUTSTANDING, 4, maximum accepted-but-incomplete bursts (1..255)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- s_axi_ar_valid  in  NUM_MASTERS  per-requester AR valid
- s_axi_ar_ready  out  NUM_MASTERS  per-requester AR ready (one-hot or zero)
- s_axi_ar_addr  in  NUM_MASTERS*AXI_ADDR_WIDTH  packed, requester i at slice i
- s_axi_ar_id  in  NUM_MASTERS*UID_W  packed IDs
- s_axi_ar_len / _size / _burst  in  NUM_MASTERS*8 / *3 / *2  packed
- m_axi_ar_valid / _ready  out / in  1  downstream AR handshake
- m_axi_ar_addr, _id, _len, _size, _burst  out  AXI_ADDR_WIDTH, AXI_ID_WIDTH, 8, 3, 2  registered payload
- m_axi_r_valid, _data, _id, _resp, _last  in  1, AXI_DATA_WIDTH, AXI_ID_WIDTH, 2, 1  downstream R
- m_axi_r_ready  out  1
- s_axi_r_valid / s_axi_r_ready  out / in  NUM_MASTERS  per-requester R handshake
- s_axi_r_data, _id, _resp, _last  out  AXI_DATA_WIDTH, UID_W, 2, 1  broadcast to all requesters

## Operation
- States: IDLE (m_axi_ar_valid=0), ISSUE (m_axi_ar_valid=1, payload held).
- Accept window: open = (IDLE or (ISSUE and m_axi_ar_ready)) and can_issue.
- can_issue = out_cnt + (ISSUE ? 1 : 0) < MAX_OUTSTANDING. The in-flight ISSUE entry counts against the cap.
- Grant: when open, pick the first requester with valid set, searching from rr_ptr upward modulo NUM_MASTERS. Drive s_axi_ar_ready[g]=1 combinationally. All other ready bits are 0.
- On upstream handshake for requester g:
  - Register the payload.
  - m_axi_ar_id = {g[IDX_W-1:0], s_axi_ar_id slice g}.
  - rr_ptr <= (g+1) mod NUM_MASTERS.
  - Next state is ISSUE.
- ISSUE with m_axi_ar_ready=1 and no new grant goes to IDLE. With a new grant it stays in ISSUE with the new payload (back-to-back).
- ISSUE with m_axi_ar_ready=0: the payload, including valid, is held bit-exact.
- out_cnt (8 bit):
  - Increments on a downstream AR handshake.
  - Decrements on an R handshake with m_axi_r_last=1.
  - If both occur in the same cycle, it is unchanged.
  - Never exceeds MAX_OUTSTANDING. Never underflows; an R last arriving with out_cnt=0 is ignored for counting.
- R routing (combinational):
  - idx = m_axi_r_id[AXI_ID_WIDTH-1 -: IDX_W].
  - s_axi_r_valid[i] = m_axi_r_valid and (idx==i).
  - m_axi_r_ready = s_axi_r_ready[idx].
  - s_axi_r_id = m_axi_r_id[UID_W-1:0].
  - idx >= NUM_MASTERS: no upstream valid, m_axi_r_ready=1 (beat is dropped).

## Timing
- Reset values:
  - state=IDLE, m_axi_ar_valid=0, m_axi_ar_* payload=0.
  - rr_ptr=0, out_cnt=0.
  - s_axi_ar_ready=0 while rst=1.
- Reset mid-burst: all of the above take effect at the next edge. An in-flight AR is abandoned; the downstream slave shares rst.
- Latency: upstream handshake in cycle n gives m_axi_ar_valid=1 in cycle n+1.
- Throughput: one AR per cycle while the downstream ready stays high and the cap is not reached.
- R path has zero latency and is combinational.
- Fairness: a continuously requesting master is granted within NUM_MASTERS grants.

## Test plan
- Reset: hold rst=1 for 3 cycles with all s_axi_ar_valid=1 -> s_axi_ar_ready=0, m_axi_ar_valid=0. After release, the first grant goes to requester 0.
- Round-robin: all 4 valid, m_axi_ar_ready=1, MAX_OUTSTANDING=4 -> grants in order 0,1,2,3 on consecutive cycles. m_axi_ar_id upper 2 bits = 0,1,2,3.
- Hold: grant requester 2 with addr 0x1000, m_axi_ar_ready=0 for 5 cycles -> m_axi_ar_addr stays 0x1000 and valid stays 1 throughout; no further s_axi_ar_ready.
- Cap: MAX_OUTSTANDING=2, two bursts accepted, no R -> third request stalls. An R beat with last=1 and id prefix 0 -> the third request is granted next cycle.
- R routing: m_axi_r_id=8'b10_000101, m_axi_r_valid=1 -> only s_axi_r_valid[2]=1 and s_axi_r_id=6'h05. m_axi_r_ready follows s_axi_r_ready[2].
- Simultaneous: an AR handshake and an R last in the same cycle with out_cnt=1 -> out_cnt stays 1.

Source files
------------

// File: rtl/axi_read_arbiter.sv
// ---------------------------------------------------------------------------
// axi_read_arbiter
//
// Round-robin arbiter that shares one downstream AXI4 read port (AR + R)
// among NUM_MASTERS upstream requesters.
//
// The winning AR payload is registered and held bit-exact until the
// downstream slave accepts it. The downstream ARID carries the requester
// index in its top IDX_W bits, so R beats can be routed back by that prefix.
// The number of accepted-but-incomplete bursts is capped at MAX_OUTSTANDING.
//
// Ports:
//   clk, rst              clock (rising edge), synchronous active-high reset
//   s_axi_ar_*            per-requester AR channels, packed with requester i
//                         at slice i; s_axi_ar_ready is one-hot or zero
//   m_axi_ar_*            downstream AR channel, registered payload
//   m_axi_r_*             downstream R channel
//   s_axi_r_valid/ready   per-requester R handshake
//   s_axi_r_data/id/      R payload broadcast to all requesters; the ID has
//     resp/last           the requester-index prefix stripped
// ---------------------------------------------------------------------------
module axi_read_arbiter #(
  parameter int NUM_MASTERS     = 4,
  parameter int AXI_ADDR_WIDTH  = 32,
  parameter int AXI_DATA_WIDTH  = 32,
  parameter int AXI_ID_WIDTH    = 8,
  parameter int MAX_OUTSTANDING = 4,
  localparam int IDX_W          = $clog2(NUM_MASTERS),
  localparam int UID_W          = AXI_ID_WIDTH - IDX_W
) (
  input  logic                                  clk,
  input  logic                                  rst,

  input  logic [NUM_MASTERS-1:0]                s_axi_ar_valid,
  output logic [NUM_MASTERS-1:0]                s_axi_ar_ready,
  input  logic [NUM_MASTERS*AXI_ADDR_WIDTH-1:0] s_axi_ar_addr,
  input  logic [NUM_MASTERS*UID_W-1:0]          s_axi_ar_id,
  input  logic [NUM_MASTERS*8-1:0]              s_axi_ar_len,
  input  logic [NUM_MASTERS*3-1:0]              s_axi_ar_size,
  input  logic [NUM_MASTERS*2-1:0]              s_axi_ar_burst,

  output logic                                  m_axi_ar_valid,
  input  logic                                  m_axi_ar_ready,
  output logic [AXI_ADDR_WIDTH-1:0]             m_axi_ar_addr,
  output logic [AXI_ID_WIDTH-1:0]               m_axi_ar_id,
  output logic [7:0]                            m_axi_ar_len,
  output logic [2:0]                            m_axi_ar_size,
  output logic [1:0]                            m_axi_ar_burst,

  input  logic                                  m_axi_r_valid,
  output logic                                  m_axi_r_ready,
  input  logic [AXI_DATA_WIDTH-1:0]             m_axi_r_data,
  input  logic [AXI_ID_WIDTH-1:0]               m_axi_r_id,
  input  logic [1:0]                            m_axi_r_resp,
  input  logic                                  m_axi_r_last,

  output logic [NUM_MASTERS-1:0]                s_axi_r_valid,
  input  logic [NUM_MASTERS-1:0]                s_axi_r_ready,
  output logic [AXI_DATA_WIDTH-1:0]             s_axi_r_data,
  output logic [UID_W-1:0]                      s_axi_r_id,
  output logic [1:0]                            s_axi_r_resp,
  output logic                                  s_axi_r_last
);

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  localparam logic [IDX_W:0] NUM_M_W = (IDX_W+1)'(NUM_MASTERS);
  localparam logic [8:0]     MAX_OS_W = 9'(MAX_OUTSTANDING);

  state_t                    state;
  state_t                    state_next;
  logic [IDX_W-1:0]          rr_ptr;
  logic [IDX_W-1:0]          rr_ptr_next;
  logic [7:0]                out_cnt;

  logic [AXI_ADDR_WIDTH-1:0] ar_addr_q;
  logic [AXI_ID_WIDTH-1:0]   ar_id_q;
  logic [7:0]                ar_len_q;
  logic [2:0]                ar_size_q;
  logic [1:0]                ar_burst_q;

  logic [8:0]                pending;
  logic                      can_issue;
  logic                      dn_fire;
  logic                      accept_open;
  logic                      up_fire;
  logic                      r_last_fire;

  logic [NUM_MASTERS-1:0]    rot_valid;
  logic                      grant_found;
  logic [IDX_W-1:0]          grant_off;
  logic [IDX_W:0]            grant_sum;
  logic [IDX_W:0]            ptr_sum;
  logic [IDX_W-1:0]          grant_idx;

  logic [AXI_ADDR_WIDTH-1:0] sel_addr;
  logic [UID_W-1:0]          sel_uid;
  logic [7:0]                sel_len;
  logic [2:0]                sel_size;
  logic [1:0]                sel_burst;

  logic [IDX_W-1:0]          r_idx;

  // The request sitting in ISSUE has not been counted in out_cnt yet, but it
  // must still count against the cap or one extra burst could slip through.
  always_comb begin
    pending     = {1'b0, out_cnt} + {8'b0, (state == ISSUE)};
    can_issue   = (pending < MAX_OS_W);
    dn_fire     = (state == ISSUE) && m_axi_ar_ready;
    accept_open = !rst && can_issue && ((state == IDLE) || dn_fire);
    up_fire     = accept_open && grant_found;
  end

  // Round-robin search: rotate the valid vector so that rr_ptr lands on
  // bit 0, take the lowest set bit, then rotate the offset back into a
  // requester index. The descending loop leaves the lowest hit last.
  always_comb begin
    rot_valid   = NUM_MASTERS'({s_axi_ar_valid, s_axi_ar_valid} >> rr_ptr);
    grant_found = 1'b0;
    grant_off   = '0;
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      if (rot_valid[k]) begin
        grant_found = 1'b1;
        grant_off   = k[IDX_W-1:0];
      end
    end

    grant_sum = {1'b0, rr_ptr} + {1'b0, grant_off};
    if (grant_sum >= NUM_M_W) begin
      grant_sum = grant_sum - NUM_M_W;
    end
    grant_idx = grant_sum[IDX_W-1:0];

    ptr_sum = {1'b0, grant_idx} + {{IDX_W{1'b0}}, 1'b1};
    if (ptr_sum >= NUM_M_W) begin
      ptr_sum = ptr_sum - NUM_M_W;
    end
    rr_ptr_next = ptr_sum[IDX_W-1:0];
  end

  // Select the winner's payload slice and raise its ready bit. The ready is
  // combinational so the requester handshakes in the same cycle it wins.
  always_comb begin
    s_axi_ar_ready = '0;
    sel_addr       = '0;
    sel_uid        = '0;
    sel_len        = '0;
    sel_size       = '0;
    sel_burst      = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant_idx == i[IDX_W-1:0]) begin
        s_axi_ar_ready[i] = up_fire;
        sel_addr          = s_axi_ar_addr[i*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
        sel_uid           = s_axi_ar_id[i*UID_W +: UID_W];
        sel_len           = s_axi_ar_len[i*8 +: 8];
        sel_size          = s_axi_ar_size[i*3 +: 3];
        sel_burst         = s_axi_ar_burst[i*2 +: 2];
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A new grant always lands in ISSUE, which also covers the back-to-back
  // case where the previous payload is accepted in the same cycle.
  always_comb begin
    state_next = state;
    if (up_fire) begin
      state_next = ISSUE;
    end else if (dn_fire) begin
      state_next = IDLE;
    end
  end

  assign m_axi_ar_valid = (state == ISSUE);

  // Payload and round-robin pointer only change on an upstream handshake,
  // so a stalled ISSUE keeps the payload bit-exact.
  always_ff @(posedge clk) begin
    if (rst) begin
      ar_addr_q  <= '0;
      ar_id_q    <= '0;
      ar_len_q   <= '0;
      ar_size_q  <= '0;
      ar_burst_q <= '0;
      rr_ptr     <= '0;
    end else if (up_fire) begin
      ar_addr_q  <= sel_addr;
      ar_id_q    <= {grant_idx, sel_uid};
      ar_len_q   <= sel_len;
      ar_size_q  <= sel_size;
      ar_burst_q <= sel_burst;
      rr_ptr     <= rr_ptr_next;
    end
  end

  assign m_axi_ar_addr  = ar_addr_q;
  assign m_axi_ar_id    = ar_id_q;
  assign m_axi_ar_len   = ar_len_q;
  assign m_axi_ar_size  = ar_size_q;
  assign m_axi_ar_burst = ar_burst_q;

  // Outstanding-burst counter. A stray last beat with nothing outstanding
  // is ignored so the count cannot wrap below zero.
  assign r_last_fire = m_axi_r_valid && m_axi_r_ready && m_axi_r_last &&
                       (out_cnt != 8'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_cnt <= 8'd0;
    end else begin
      case ({dn_fire, r_last_fire})
        2'b10:   out_cnt <= out_cnt + 8'd1;
        2'b01:   out_cnt <= out_cnt - 8'd1;
        default: out_cnt <= out_cnt;
      endcase
    end
  end

  // R routing by the ID prefix. A prefix that matches no requester leaves
  // every upstream valid low and keeps ready high so the beat is drained.
  assign r_idx = m_axi_r_id[AXI_ID_WIDTH-1 -: IDX_W];

  always_comb begin
    s_axi_r_valid = '0;
    m_axi_r_ready = 1'b1;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (r_idx == i[IDX_W-1:0]) begin
        s_axi_r_valid[i] = m_axi_r_valid;
        m_axi_r_ready    = s_axi_r_ready[i];
      end
    end
  end

  assign s_axi_r_data = m_axi_r_data;
  assign s_axi_r_id   = m_axi_r_id[UID_W-1:0];
  assign s_axi_r_resp = m_axi_r_resp;
  assign s_axi_r_last = m_axi_r_last;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axi_read_arbiter
//
// Directed bench for axi_read_arbiter with 4 requesters, 32-bit address and
// data, 8-bit downstream ID and an outstanding cap of 4.
// ---------------------------------------------------------------------------
module tb_axi_read_arbiter;

  localparam int NM    = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int IW    = 8;
  localparam int UID_W = 6;

  logic               clk;
  logic               rst;

  logic [NM-1:0]      s_axi_ar_valid;
  logic [NM-1:0]      s_axi_ar_ready;
  logic [NM*AW-1:0]   s_axi_ar_addr;
  logic [NM*UID_W-1:0] s_axi_ar_id;
  logic [NM*8-1:0]    s_axi_ar_len;
  logic [NM*3-1:0]    s_axi_ar_size;
  logic [NM*2-1:0]    s_axi_ar_burst;

  logic               m_axi_ar_valid;
  logic               m_axi_ar_ready;
  logic [AW-1:0]      m_axi_ar_addr;
  logic [IW-1:0]      m_axi_ar_id;
  logic [7:0]         m_axi_ar_len;
  logic [2:0]         m_axi_ar_size;
  logic [1:0]         m_axi_ar_burst;

  logic               m_axi_r_valid;
  logic               m_axi_r_ready;
  logic [DW-1:0]      m_axi_r_data;
  logic [IW-1:0]      m_axi_r_id;
  logic [1:0]         m_axi_r_resp;
  logic               m_axi_r_last;

  logic [NM-1:0]      s_axi_r_valid;
  logic [NM-1:0]      s_axi_r_ready;
  logic [DW-1:0]      s_axi_r_data;
  logic [UID_W-1:0]   s_axi_r_id;
  logic [1:0]         s_axi_r_resp;
  logic               s_axi_r_last;

  int chk_cnt = 0;
  int err_cnt = 0;

  axi_read_arbiter #(
    .NUM_MASTERS     (NM),
    .AXI_ADDR_WIDTH  (AW),
    .AXI_DATA_WIDTH  (DW),
    .AXI_ID_WIDTH    (IW),
    .MAX_OUTSTANDING (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .s_axi_ar_valid (s_axi_ar_valid),
    .s_axi_ar_ready (s_axi_ar_ready),
    .s_axi_ar_addr  (s_axi_ar_addr),
    .s_axi_ar_id    (s_axi_ar_id),
    .s_axi_ar_len   (s_axi_ar_len),
    .s_axi_ar_size  (s_axi_ar_size),
    .s_axi_ar_burst (s_axi_ar_burst),
    .m_axi_ar_valid (m_axi_ar_valid),
    .m_axi_ar_ready (m_axi_ar_ready),
    .m_axi_ar_addr  (m_axi_ar_addr),
    .m_axi_ar_id    (m_axi_ar_id),
    .m_axi_ar_len   (m_axi_ar_len),
    .m_axi_ar_size  (m_axi_ar_size),
    .m_axi_ar_burst (m_axi_ar_burst),
    .m_axi_r_valid  (m_axi_r_valid),
    .m_axi_r_ready  (m_axi_r_ready),
    .m_axi_r_data   (m_axi_r_data),
    .m_axi_r_id     (m_axi_r_id),
    .m_axi_r_resp   (m_axi_r_resp),
    .m_axi_r_last   (m_axi_r_last),
    .s_axi_r_valid  (s_axi_r_valid),
    .s_axi_r_ready  (s_axi_r_ready),
    .s_axi_r_data   (s_axi_r_data),
    .s_axi_r_id     (s_axi_r_id),
    .s_axi_r_resp   (s_axi_r_resp),
    .s_axi_r_last   (s_axi_r_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    chk_cnt++;
    if (actual !== expected) begin
      err_cnt++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Loads one requester's AR slice.
  task automatic applyStimulus(input int m, input logic [AW-1:0] addr,
                               input logic [UID_W-1:0] uid, input logic [7:0] len);
    s_axi_ar_addr[m*AW +: AW]        = addr;
    s_axi_ar_id[m*UID_W +: UID_W]    = uid;
    s_axi_ar_len[m*8 +: 8]           = len;
    s_axi_ar_size[m*3 +: 3]          = 3'd2;
    s_axi_ar_burst[m*2 +: 2]         = 2'd1;
  endtask

  // Advance past a rising edge; inputs are changed away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] exp_id [4];
    logic [3:0] exp_rdy [4];
    int grants;

    exp_id  = '{8'h10, 8'h51, 8'h92, 8'hD3};
    exp_rdy = '{4'b0010, 4'b0100, 4'b1000, 4'b0000};

    rst            = 1'b1;
    s_axi_ar_valid = 4'hF;
    s_axi_ar_addr  = '0;
    s_axi_ar_id    = '0;
    s_axi_ar_len   = '0;
    s_axi_ar_size  = '0;
    s_axi_ar_burst = '0;
    m_axi_ar_ready = 1'b0;
    m_axi_r_valid  = 1'b0;
    m_axi_r_data   = '0;
    m_axi_r_id     = '0;
    m_axi_r_resp   = '0;
    m_axi_r_last   = 1'b0;
    s_axi_r_ready  = '0;
    for (int i = 0; i < NM; i++) begin
      applyStimulus(i, 32'h100 * (i + 1), 6'h10 + 6'(i), 8'(i));
    end

    // Reset held for three cycles with every requester asking.
    for (int c = 0; c < 3; c++) begin
      tick();
      checkOutput("rst_ar_ready", 64'(s_axi_ar_ready), 64'h0);
      checkOutput("rst_ar_valid", 64'(m_axi_ar_valid), 64'h0);
    end
    checkOutput("rst_ar_addr", 64'(m_axi_ar_addr), 64'h0);

    rst            = 1'b0;
    m_axi_ar_ready = 1'b1;
    #1;
    checkOutput("first_grant", 64'(s_axi_ar_ready), 64'h1);

    // Round-robin 0,1,2,3 back-to-back; the fourth issue fills the cap.
    for (int g = 0; g < 4; g++) begin
      tick();
      checkOutput("rr_ar_valid", 64'(m_axi_ar_valid), 64'h1);
      checkOutput("rr_ar_id", 64'(m_axi_ar_id), 64'(exp_id[g]));
      checkOutput("rr_ar_addr", 64'(m_axi_ar_addr), 64'(32'h100 * (g + 1)));
      checkOutput("rr_next_ready", 64'(s_axi_ar_ready), 64'(exp_rdy[g]));
    end
    checkOutput("rr_ar_len", 64'(m_axi_ar_len), 64'h3);

    tick();
    checkOutput("cap_idle_valid", 64'(m_axi_ar_valid), 64'h0);
    checkOutput("cap_idle_ready", 64'(s_axi_ar_ready), 64'h0);

    // R routing by ID prefix 2'b10.
    m_axi_r_valid = 1'b1;
    m_axi_r_id    = 8'b10_000101;
    m_axi_r_data  = 32'hCAFE0002;
    m_axi_r_resp  = 2'b01;
    s_axi_r_ready = 4'b0100;
    #1;
    checkOutput("r_valid_route", 64'(s_axi_r_valid), 64'h4);
    checkOutput("r_uid", 64'(s_axi_r_id), 64'h05);
    checkOutput("r_data", 64'(s_axi_r_data), 64'hCAFE0002);
    checkOutput("r_resp", 64'(s_axi_r_resp), 64'h1);
    checkOutput("r_ready_hi", 64'(m_axi_r_ready), 64'h1);
    s_axi_r_ready = 4'b1011;
    #1;
    checkOutput("r_ready_lo", 64'(m_axi_r_ready), 64'h0);

    // A last beat for requester 0 frees one slot.
    m_axi_r_id    = 8'h10;
    m_axi_r_last  = 1'b1;
    s_axi_r_ready = 4'b0001;
    #1;
    checkOutput("r_valid_m0", 64'(s_axi_r_valid), 64'h1);
    checkOutput("cap_still_full", 64'(s_axi_ar_ready), 64'h0);
    tick();
    m_axi_r_valid = 1'b0;
    m_axi_r_last  = 1'b0;
    #1;
    checkOutput("cap_release", 64'(s_axi_ar_ready), 64'h1);

    // Hold: requester 2 wins, downstream stalls for five cycles.
    s_axi_ar_valid = 4'b0100;
    applyStimulus(2, 32'h1000, 6'h22, 8'h0);
    m_axi_ar_ready = 1'b0;
    #1;
    checkOutput("hold_grant", 64'(s_axi_ar_ready), 64'h4);
    tick();
    s_axi_ar_valid = 4'b0001;
    for (int c = 0; c < 5; c++) begin
      #1;
      checkOutput("hold_valid", 64'(m_axi_ar_valid), 64'h1);
      checkOutput("hold_addr", 64'(m_axi_ar_addr), 64'h1000);
      checkOutput("hold_id", 64'(m_axi_ar_id), 64'hA2);
      checkOutput("hold_no_ready", 64'(s_axi_ar_ready), 64'h0);
      tick();
    end

    // Reset while a request is stalled abandons it.
    rst            = 1'b1;
    s_axi_ar_valid = 4'b0000;
    tick();
    rst = 1'b0;
    #1;
    checkOutput("midrst_valid", 64'(m_axi_ar_valid), 64'h0);
    checkOutput("midrst_addr", 64'(m_axi_ar_addr), 64'h0);

    // Build out_cnt=1, then overlap an AR handshake with an R last.
    s_axi_ar_valid = 4'b0001;
    m_axi_ar_ready = 1'b1;
    #1;
    checkOutput("sim_grant0", 64'(s_axi_ar_ready), 64'h1);
    tick();
    s_axi_ar_valid = 4'b0000;
    tick();
    checkOutput("sim_idle", 64'(m_axi_ar_valid), 64'h0);
    s_axi_ar_valid = 4'b0010;
    #1;
    checkOutput("sim_grant1", 64'(s_axi_ar_ready), 64'h2);
    tick();
    s_axi_ar_valid = 4'b0000;
    m_axi_r_valid  = 1'b1;
    m_axi_r_last   = 1'b1;
    m_axi_r_id     = 8'h40;
    s_axi_r_ready  = 4'b0010;
    #1;
    checkOutput("sim_r_ready", 64'(m_axi_r_ready), 64'h1);
    tick();
    m_axi_r_valid  = 1'b0;
    m_axi_r_last   = 1'b0;

    // With out_cnt=1 exactly three more grants fit under the cap of 4.
    s_axi_ar_valid = 4'hF;
    #1;
    checkOutput("sim_first_ptr", 64'(s_axi_ar_ready), 64'h4);
    grants = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (s_axi_ar_ready != 4'b0000) grants++;
      tick();
    end
    checkOutput("sim_out_cnt", 64'(grants), 64'h3);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
